// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for a bank of common-anode 7-segment digits.
//   A prescaler divides clk into digit slots; each slot begins with one
//   blanked (dead-time) cycle to avoid ghosting, then drives its digit.
//   New values are staged in a pending register and committed to the
//   display register only on the frame boundary, so a frame never mixes
//   old and new digits.
//
// Parameters
//   NUM_DIGITS  number of multiplexed digits (1..8)
//   SCAN_DIV    clock cycles per digit slot (>= 2)
//
// Ports
//   clk         clock, all state on rising edge
//   rst_n       synchronous active-low reset
//   load        capture value/dp_in this cycle
//   value       one nibble per digit, digit 0 in value[3:0]
//   dp_in       decimal point request per digit, 1 = lit
//   hex_mode    1 = show 10..15 as A..F, 0 = show as dash
//   lz_blank    1 = blank leading zeros (digit 0 never blanked)
//   seg_n       segments {g,f,e,d,c,b,a}, active-low, registered
//   dp_n        decimal point, active-low, registered
//   an_n        digit enables, active-low one-hot, registered
//   frame_done  one-cycle pulse after the display register updates
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    hex_mode,
  input  logic                    lz_blank,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] PRESC_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_OFF    = 7'h7F;
  localparam logic [6:0]    SEG_DASH   = 7'h3F;

  // Scan timing
  logic [CW-1:0] presc;
  logic [IW-1:0] idx;
  logic          slot_tick;
  logic          frame_wrap;

  // Value storage
  logic [VW-1:0]         disp_val;
  logic [NUM_DIGITS-1:0] disp_dp;
  logic [VW-1:0]         pend_val;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic                  pend_vld;
  logic                  disp_take;

  // Output path
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic [IW-1:0]         msd_idx;
  logic                  blank;
  logic                  dead;
  logic [6:0]            seg_d;
  logic                  dp_d;
  logic [NUM_DIGITS-1:0] an_d;

  assign slot_tick  = (presc == PRESC_LAST);
  assign frame_wrap = slot_tick && (idx == IDX_LAST);
  assign disp_take  = frame_wrap && (load || pend_vld);
  assign dead       = (presc == '0);

  // Segment pattern {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] glyph(input logic [3:0] nib, input logic hex);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      default: g = 7'h0E;
    endcase
    if (!hex && (nib > 4'h9)) begin
      g = SEG_DASH;
    end
    return g;
  endfunction

  // Nibble and decimal point of the digit owning the current slot.
  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib = disp_val[4*i +: 4];
        cur_dp  = disp_dp[i];
      end
    end
  end

  // Highest nonzero digit of the displayed value; 0 when all digits are zero,
  // which keeps digit 0 always visible.
  always_comb begin
    msd_idx = '0;
    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
      if (disp_val[4*i +: 4] != 4'h0) begin
        msd_idx = IW'(i);
      end
    end
  end

  assign blank = lz_blank && (idx > msd_idx);

  // Next output values; the first cycle of each slot is dead time.
  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    an_d  = '1;
    if (!dead) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (idx == IW'(i)) begin
          an_d[i] = 1'b0;
        end
      end
      dp_d = ~cur_dp;
      if (!blank) begin
        seg_d = glyph(cur_nib, hex_mode);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_vld   <= 1'b0;
      seg_n      <= SEG_OFF;
      dp_n       <= 1'b1;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      presc <= slot_tick ? '0 : presc + 1'b1;
      if (slot_tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end

      // A load landing on the frame boundary goes straight to the display
      // and supersedes anything still pending.
      if (frame_wrap && load) begin
        disp_val <= value;
        disp_dp  <= dp_in;
        pend_vld <= 1'b0;
      end else if (frame_wrap && pend_vld) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
        pend_vld <= 1'b0;
      end else if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
        pend_vld <= 1'b1;
      end

      frame_done <= disp_take;
      seg_n      <= seg_d;
      dp_n       <= dp_d;
      an_n       <= an_d;
    end
  end

endmodule
